// File: rtl/seg_lfsr_checker.sv
// seg_lfsr_checker
// Receive-side checker for the LFSR / seven-segment display path. Decodes a
// two-digit active-low segment pattern back into a byte and checks that
// the byte stream follows the 8-bit LFSR successor rule. It acquires lock,
// tracks loss of lock and counts errors.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_seg_valid    i_seg_in carries a new sample this cycle
//   i_seg_in[15:0] [15:8] high digit, [7:0] low digit; bit7=a .. bit1=g, bit0=dp
//   i_clr_err      synchronous clear of o_err_cnt (wins over an increment)
//   o_byte_out     decoded byte {hi nibble, lo nibble}
//   o_byte_valid   o_byte_out updated this cycle
//   o_code_err     qualifies o_byte_valid: at least one digit code is illegal
//   o_locked       checker is in LOCKED
//   o_mismatch     one-cycle pulse when a checked byte fails
//   o_err_cnt      saturating count of mismatches while locked
module seg_lfsr_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_seg_valid,
  input  logic [15:0]      i_seg_in,
  input  logic             i_clr_err,
  output logic [7:0]       o_byte_out,
  output logic             o_byte_valid,
  output logic             o_code_err,
  output logic             o_locked,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_HUNT   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // Digit decode: returns {illegal, nibble}; illegal codes decode as nibble 0.
  function automatic logic [4:0] dec_digit(input logic [7:0] code);
    logic [4:0] res;
    case (code)
      8'h03:   res = 5'h00;
      8'h9F:   res = 5'h01;
      8'h25:   res = 5'h02;
      8'h0D:   res = 5'h03;
      8'h99:   res = 5'h04;
      8'h49:   res = 5'h05;
      8'h41:   res = 5'h06;
      8'h1F:   res = 5'h07;
      8'h01:   res = 5'h08;
      8'h09:   res = 5'h09;
      8'h11:   res = 5'h0A;
      8'hC1:   res = 5'h0B;
      8'h63:   res = 5'h0C;
      8'h85:   res = 5'h0D;
      8'h61:   res = 5'h0E;
      8'h71:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  // LFSR successor.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[4] ^ q[3] ^ q[2] ^ q[0], q[7:1]};
  endfunction

  // ---------------- stage 1: decode ----------------
  logic [4:0] w_hi;
  logic [4:0] w_lo;
  logic [7:0] r_byte_out;
  logic       r_byte_valid;
  logic       r_code_err;

  assign w_hi = dec_digit(i_seg_in[15:8]);
  assign w_lo = dec_digit(i_seg_in[7:0]);

  // Capture a decoded sample; byte_out holds between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_out   <= 8'h00;
      r_byte_valid <= 1'b0;
      r_code_err   <= 1'b0;
    end else begin
      r_byte_valid <= i_seg_valid;
      if (i_seg_valid) begin
        r_byte_out <= {w_hi[3:0], w_lo[3:0]};
        r_code_err <= w_hi[4] | w_lo[4];
      end else begin
        r_code_err <= 1'b0;
      end
    end
  end

  // ---------------- stage 2: sequence check FSM ----------------
  logic [1:0]       r_state;
  logic [7:0]       r_exp;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] r_miss;
  logic             r_locked;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err_cnt;

  logic [1:0]       w_state_nxt;
  logic [7:0]       w_exp_nxt;
  logic [CNT_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_miss_nxt;
  logic             w_mismatch_nxt;
  logic             w_err_inc;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_good;
  logic             w_match;
  logic [CNT_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_miss_inc;

  // A usable seed is a legal, non-zero byte (0x00 is the LFSR lock-up state).
  assign w_good     = !r_code_err && (r_byte_out != 8'h00);
  assign w_match    = !r_code_err && (r_byte_out == r_exp);
  assign w_run_inc  = r_run + CNT_W'(1);
  assign w_miss_inc = r_miss + CNT_W'(1);

  // Next-state and next-output logic; only acts on a valid decoded byte.
  always_comb begin
    w_state_nxt    = r_state;
    w_exp_nxt      = r_exp;
    w_run_nxt      = r_run;
    w_miss_nxt     = r_miss;
    w_mismatch_nxt = 1'b0;
    w_err_inc      = 1'b0;
    if (r_byte_valid) begin
      case (r_state)
        S_HUNT: begin
          if (w_good) begin
            w_exp_nxt   = lfsr_next(r_byte_out);
            w_run_nxt   = '0;
            w_state_nxt = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (w_match) begin
            w_run_nxt = w_run_inc;
            w_exp_nxt = lfsr_next(r_byte_out);
            if (w_run_inc == CNT_W'(LOCK_CNT)) begin
              w_state_nxt = S_LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_mismatch_nxt = 1'b1;
            if (w_good) begin
              w_exp_nxt = lfsr_next(r_byte_out);
              w_run_nxt = '0;
            end else begin
              w_state_nxt = S_HUNT;
            end
          end
        end
        S_LOCKED: begin
          // Flywheel: expectation advances on every byte, never reseeded.
          w_exp_nxt = lfsr_next(r_exp);
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_mismatch_nxt = 1'b1;
            w_err_inc      = 1'b1;
            w_miss_nxt     = w_miss_inc;
            if (w_miss_inc == CNT_W'(LOSS_CNT)) begin
              w_state_nxt = S_HUNT;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment.
  always_comb begin
    w_err_nxt = r_err_cnt;
    if (i_clr_err) begin
      w_err_nxt = '0;
    end else if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
      w_err_nxt = r_err_cnt + ERR_W'(1);
    end
  end

  // State and registered stage-2 outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HUNT;
      r_exp      <= 8'h00;
      r_run      <= '0;
      r_miss     <= '0;
      r_locked   <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_exp      <= w_exp_nxt;
      r_run      <= w_run_nxt;
      r_miss     <= w_miss_nxt;
      r_locked   <= (w_state_nxt == S_LOCKED);
      r_mismatch <= w_mismatch_nxt;
      r_err_cnt  <= w_err_nxt;
    end
  end

  assign o_byte_out   = r_byte_out;
  assign o_byte_valid = r_byte_valid;
  assign o_code_err   = r_code_err;
  assign o_locked     = r_locked;
  assign o_mismatch   = r_mismatch;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_seg_lfsr_checker.sv
// Testbench for seg_lfsr_checker: directed steps plus randomized traffic,
// compared every cycle against a behavioural model of the checker.
module tb_seg_lfsr_checker;

  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned LOSS_CNT = 3;
  localparam int unsigned ERR_W    = 8;
  localparam int          ERR_MAX  = (1 << ERR_W) - 1;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             seg_valid = 1'b0;
  logic [15:0]      seg_in = 16'h0000;
  logic             clr_err = 1'b0;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             code_err;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  // Model: stage-1 view
  bit       m_bv;
  bit [7:0] m_byte;
  bit       m_cerr;
  // Model: checker view
  bit       m_tracking;   // seeded (verifying or locked)
  bit       m_locked;
  bit [7:0] m_exp;
  int       m_run;
  int       m_miss;
  bit       m_mis;
  int       m_err;

  always #5 clk = ~clk;

  seg_lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_seg_valid  (seg_valid),
    .i_seg_in     (seg_in),
    .i_clr_err    (clr_err),
    .o_byte_out   (byte_out),
    .o_byte_valid (byte_valid),
    .o_code_err   (code_err),
    .o_locked     (locked),
    .o_mismatch   (mismatch),
    .o_err_cnt    (err_cnt)
  );

  function automatic bit [7:0] succ(input bit [7:0] q);
    return {^(q & 8'h1D), q[7:1]};
  endfunction

  function automatic logic [15:0] enc(input logic [7:0] b);
    return {SEG_TAB[b[7:4]], SEG_TAB[b[3:0]]};
  endfunction

  task automatic decode(input logic [15:0] s, output bit [7:0] b, output bit err);
    bit fh = 0;
    bit fl = 0;
    b = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (SEG_TAB[i] == s[15:8]) begin b[7:4] = 4'(i); fh = 1; end
      if (SEG_TAB[i] == s[7:0])  begin b[3:0] = 4'(i); fl = 1; end
    end
    err = !(fh && fl);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_bv = 0; m_byte = 0; m_cerr = 0;
    m_tracking = 0; m_locked = 0; m_exp = 0;
    m_run = 0; m_miss = 0; m_mis = 0; m_err = 0;
  endtask

  // Checker behaviour for one clock edge given the decoded byte seen then.
  task automatic model_check(input bit bv, input bit [7:0] b, input bit cerr, input bit clr);
    bit inc  = 0;
    bit good = !cerr && (b != 8'h00);
    bit hit  = !cerr && (b == m_exp);
    m_mis = 0;
    if (bv) begin
      if (!m_tracking) begin
        if (good) begin m_tracking = 1; m_exp = succ(b); m_run = 0; end
      end else if (!m_locked) begin
        if (hit) begin
          m_run++;
          m_exp = succ(b);
          if (m_run == int'(LOCK_CNT)) begin m_locked = 1; m_miss = 0; end
        end else begin
          m_mis = 1;
          if (good) begin m_exp = succ(b); m_run = 0; end
          else m_tracking = 0;
        end
      end else begin
        m_exp = succ(m_exp);
        if (hit) m_miss = 0;
        else begin
          m_mis = 1; inc = 1; m_miss++;
          if (m_miss == int'(LOSS_CNT)) begin m_locked = 0; m_tracking = 0; end
        end
      end
    end
    if (clr) m_err = 0;
    else if (inc && m_err < ERR_MAX) m_err++;
  endtask

  task automatic cmp_all();
    chk("byte_valid", 32'(byte_valid), 32'(m_bv));
    chk("byte_out",   32'(byte_out),   32'(m_byte));
    chk("code_err",   32'(code_err),   32'(m_cerr));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("mismatch",   32'(mismatch),   32'(m_mis));
    chk("err_cnt",    32'(err_cnt),    32'(m_err));
  endtask

  // One clock: drive inputs, advance, update the model, compare all outputs.
  task automatic step(input bit v, input logic [15:0] s, input bit clr);
    bit       pbv = m_bv;
    bit [7:0] pb  = m_byte;
    bit       pce = m_cerr;
    bit [7:0] db;
    bit       de;
    seg_valid = v; seg_in = s; clr_err = clr;
    @(posedge clk); #1;
    model_check(pbv, pb, pce, clr);
    if (v) begin decode(s, db, de); m_byte = db; m_cerr = de; end
    else m_cerr = 0;
    m_bv = v;
    cmp_all();
  endtask

  task automatic idle();
    step(0, 16'h0000, 0);
  endtask

  // A sample followed by an idle cycle so the model's expectation is current.
  task automatic send(input logic [7:0] b);
    step(1, enc(b), 0);
    idle();
  endtask

  task automatic acquire(input logic [7:0] seed);
    send(seed);
    for (int i = 0; i < int'(LOCK_CNT); i++) send(m_exp);
  endtask

  initial begin
    logic [7:0] nb;
    logic [7:0] b;
    model_reset();
    #12;
    cmp_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back stream 01,80,40,20,10,88
    step(1, 16'h039F, 0);
    step(1, 16'h0103, 0);
    step(1, 16'h9903, 0);
    step(1, 16'h2503, 0);
    step(1, 16'h9F03, 0);
    step(1, 16'h0101, 0);
    idle(); idle();
    chk("locked_after_stream", 32'(locked), 32'd1);

    // One corrupt byte then the correct sequence: stays locked, one error
    send(m_exp ^ 8'h01);
    chk("err_one", 32'(err_cnt), 32'd1);
    send(m_exp); send(m_exp);
    chk("locked_after_glitch", 32'(locked), 32'd1);

    // Three zero bytes lose lock
    step(1, 16'h0303, 0);
    step(1, 16'h0303, 0);
    step(1, 16'h0303, 0);
    idle();
    chk("locked_after_loss", 32'(locked), 32'd0);
    chk("err_after_loss", 32'(err_cnt), 32'd4);

    // Illegal code (dp lit) in HUNT
    step(1, 16'h03FE, 0);
    chk("dp_code_err", 32'(code_err), 32'd1);
    chk("dp_byte", 32'(byte_out), 32'd0);
    idle();
    chk("dp_no_pulse", 32'(mismatch), 32'd0);

    // Back-to-back lock from another seed
    nb = 8'h5A;
    for (int i = 0; i <= int'(LOCK_CNT); i++) begin
      step(1, enc(nb), 0);
      nb = succ(nb);
    end
    idle(); idle();
    chk("locked_b2b", 32'(locked), 32'd1);

    // Saturation of err_cnt, then clear on a mismatch cycle
    step(0, 16'h0000, 1);
    for (int i = 0; i < ERR_MAX + 5; i++) begin
      send(m_exp ^ 8'h10);
      send(m_exp);
    end
    chk("err_saturated", 32'(err_cnt), 32'(ERR_MAX));
    send(m_exp ^ 8'h10);
    chk("err_stays_sat", 32'(err_cnt), 32'(ERR_MAX));
    step(1, enc(m_exp ^ 8'h10), 0);
    step(0, 16'h0000, 1);
    chk("clr_beats_inc", 32'(err_cnt), 32'd0);
    chk("clr_cycle_pulse", 32'(mismatch), 32'd1);

    // Asynchronous reset mid-stream while locked
    send(m_exp); send(m_exp);
    send(m_exp ^ 8'h02);
    step(1, enc(m_exp), 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    acquire(8'hC3);
    chk("relock_after_rst", 32'(locked), 32'd1);

    // Randomized traffic
    nb = succ(8'hC3);
    for (int i = 0; i < 1500; i++) begin
      int r = $urandom_range(0, 9);
      bit c = ($urandom_range(0, 19) == 0);
      case (r)
        0, 1: step(0, 16'(SEG_TAB[$urandom_range(0, 15)]), c);
        2, 3, 4: begin step(1, enc(nb), c); nb = succ(nb); end
        5: step(1, 16'h0303, c);
        6: step(1, 16'($urandom()), c);
        default: begin
          b = 8'($urandom());
          step(1, enc(b), c);
          nb = succ(b);
        end
      endcase
    end
    idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
